// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the SAP-3 CPU clock controller.
// Imported by the controller top and its step-input conditioner.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        CS_IDLE = 2'd0,
        CS_RUN  = 2'd1,
        CS_STEP = 2'd2,
        CS_HALT = 2'd3
    } clk_state_e;

    localparam int DIV_W_DEF = 8;
    localparam int CYC_W_DEF = 16;

    // States in which the divider counts and clk_o may be high.
    function automatic logic is_clocking(input clk_state_e s);
        return (s == CS_RUN) || (s == CS_STEP);
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a
// registered single-cycle rising-edge pulse.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller producing a programmable divided CPU clock
// with an aligned tick; start and stop only at half-period boundaries.
module cpu_clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CYC_W = CYC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic [CYC_W-1:0] cyc_cnt_o
);

    clk_state_e       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             halted_q, halted_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic step_rise;
    logic boundary;

    sync_rise_det u_step_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (step_i),
        .rise_o  (step_rise)
    );

    assign boundary = (cnt_q == div_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        cyc_d   = cyc_q;

        case (state_q)
            CS_IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                // run wins over a coincident step edge, which is dropped
                if (halt_i) begin
                    state_d = CS_HALT;
                end else if (run_i) begin
                    state_d = CS_RUN;
                    div_d   = div_i;
                end else if (step_rise) begin
                    state_d = CS_STEP;
                    div_d   = div_i;
                end
            end

            CS_RUN, CS_STEP: begin
                if (boundary) begin
                    cnt_d = '0;
                    div_d = div_i;
                    if (clk_q) begin
                        clk_d = 1'b0;
                        if (state_q == CS_STEP) begin
                            state_d = CS_IDLE;
                        end
                    end else if ((state_q == CS_RUN) && halt_i) begin
                        state_d = CS_HALT;
                    end else if ((state_q == CS_RUN) && !run_i) begin
                        state_d = CS_IDLE;
                    end else begin
                        clk_d  = 1'b1;
                        tick_d = 1'b1;
                        cyc_d  = cyc_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            CS_HALT: begin
                cnt_d = '0;
                clk_d = 1'b0;
            end

            default: begin
                state_d = CS_IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase

        // Counter must never hold a stale value outside the clocking states.
        if (!is_clocking(state_d)) begin
            cnt_d = '0;
        end

        halted_d = (state_d == CS_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CS_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            halted_q <= 1'b0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            halted_q <= halted_d;
            cyc_q    <= cyc_d;
        end
    end

    assign clk_o     = clk_q;
    assign tick_o    = tick_q;
    assign state_o   = state_q;
    assign halted_o  = halted_q;
    assign cyc_cnt_o = cyc_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl: stimulus predicts tick edges, counts
// and high-phase lengths; a negedge monitor pops and compares them.
module tb_cpu_clk_ctrl;
    import clk_ctrl_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_i = 1'b0;
    logic          step_i = 1'b0;
    logic          halt_i = 1'b0;
    logic [DW-1:0] div_i = '0;
    logic          clk_o;
    logic          tick_o;
    logic [1:0]    state_o;
    logic          halted_o;
    logic [CW-1:0] cyc_cnt_o;

    cpu_clk_ctrl #(.DIV_W(DW), .CYC_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (run_i),
        .step_i    (step_i),
        .halt_i    (halt_i),
        .div_i     (div_i),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .state_o   (state_o),
        .halted_o  (halted_o),
        .cyc_cnt_o (cyc_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_n;
        int cnt;
        int hi;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ecnt = 0;
    int   ticks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, expv, ecnt);
        end
    endtask

    task automatic push_tick(input int edge_n, input int hi);
        exp_t e;
        ticks++;
        e.edge_n = edge_n;
        e.cnt    = ticks % (1 << CW);
        e.hi     = hi;
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        ecnt++;
    end

    // Monitor: every tick must match the head of the scoreboard
    initial begin
        exp_t cur;
        bit   meas;
        int   hi_len;
        meas = 0;
        hi_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                meas = 0;
            end else begin
                if (meas) begin
                    if (clk_o) begin
                        hi_len++;
                    end else begin
                        chk("high_len", hi_len, cur.hi);
                        meas = 0;
                    end
                end
                if (tick_o) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_tick: got tick at edge %0d expected none", ecnt);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("tick_edge", ecnt, cur.edge_n);
                        chk("tick_cyc", cyc_cnt_o, cur.cnt);
                        chk("tick_clk", clk_o, 1);
                        meas = 1;
                        hi_len = 1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n  = 1'b0;
        run_i  = 1'b0;
        step_i = 1'b0;
        halt_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk", clk_o, 0);
        chk("rst_tick", tick_o, 0);
        chk("rst_state", state_o, CS_IDLE);
        chk("rst_halted", halted_o, 0);
        chk("rst_cyc", cyc_cnt_o, 0);
        rst_n = 1'b1;
        ticks = 0;
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge from CS_IDLE; run_i is high for r sampled edges.
    task automatic run_burst(input int d, input int r);
        int base;
        base  = ecnt;
        div_i = DW'(d);
        run_i = 1'b1;
        for (int k = 0; base + 1 + (d + 1) * (2 * k + 1) <= base + r; k++)
            push_tick(base + 1 + (d + 1) * (2 * k + 1), d + 1);
        @(posedge clk);
        #1;
        chk("burst_run_state", state_o, CS_RUN);
        repeat (r - 1) @(posedge clk);
        #1;
        run_i = 1'b0;
        repeat (2 * (d + 1) + 4) @(posedge clk);
        #1;
        chk("burst_idle_state", state_o, CS_IDLE);
        chk("burst_idle_clk", clk_o, 0);
    endtask

    initial begin
        int base;
        do_reset();

        run_burst(1, 40);
        chk("cyc_after_40", cyc_cnt_o, 10);

        run_burst(2, 5);

        // Ratio change during a high phase applies from the next boundary
        base  = ecnt;
        div_i = 8'd3;
        run_i = 1'b1;
        push_tick(base + 5, 4);
        push_tick(base + 10, 1);
        push_tick(base + 12, 1);
        push_tick(base + 14, 1);
        @(posedge clk);
        #1;
        chk("divchg_state", state_o, CS_RUN);
        repeat (5) @(posedge clk);
        #1;
        div_i = 8'd0;
        repeat (9) @(posedge clk);
        #1;
        run_i = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("divchg_idle", state_o, CS_IDLE);

        // Single step, with a second pulse arriving while still stepping
        div_i = 8'd4;
        #2;
        step_i = 1'b1;
        base = ecnt;
        push_tick(base + 9, 5);
        repeat (4) @(posedge clk);
        #1;
        chk("step_state", state_o, CS_STEP);
        @(posedge clk);
        #3;
        step_i = 1'b0;
        @(posedge clk);
        #3;
        step_i = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        step_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("step_idle", state_o, CS_IDLE);
        chk("step_idle_clk", clk_o, 0);

        // Step edge landing in the same cycle run_i is first seen
        #1;
        step_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        step_i = 1'b0;
        run_burst(1, 9);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_burst($urandom_range(0, 5), $urandom_range(1, 30));
        end

        // Halt raised in a high phase: fall completes, then sticky halt
        base  = ecnt;
        div_i = 8'd2;
        run_i = 1'b1;
        push_tick(base + 4, 3);
        repeat (5) @(posedge clk);
        #1;
        halt_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("halt_state", state_o, CS_HALT);
        chk("halt_flag", halted_o, 1);
        chk("halt_clk", clk_o, 0);
        run_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_i = 1'b1;
        #2;
        step_i = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        step_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("halt_sticky", state_o, CS_HALT);
        chk("halt_sticky_flag", halted_o, 1);
        do_reset();

        run_burst(0, 34);
        chk("cyc_wrap", cyc_cnt_o, 1);

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
